// File: rtl/ahb_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : integration_pkg
// Description : Shared AHB 2.0 encodings and arbiter state type used by
//               ahb_bus_arbiter and ahb_rr_picker. Also provides burst_len(),
//               which maps an hburst code to its fixed beat count
//               (1 for SINGLE and undefined-length INCR).
// Contents    : htrans_e, hburst_e, hresp_e, arb_state_e, burst_len()
// Revision    : 1.0 - initial release
// ============================================================================
package integration_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        OKAY  = 2'd0,
        ERROR = 2'd1,
        RETRY = 2'd2,
        SPLIT = 2'd3
    } hresp_e;

    // Arbiter ownership state. Encoding 2'd3 is unused.
    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    localparam int C_HMASTER_W = 4;
    localparam int C_BEATS_W   = 4;

    // Number of beats in a fixed-length burst. SINGLE and INCR count as one
    // beat so the counter loads zero and never freezes arbitration.
    function automatic logic [4:0] burst_len(input hburst_e burst);
        case (burst)
            WRAP4,  INCR4:  burst_len = 5'd4;
            WRAP8,  INCR8:  burst_len = 5'd8;
            WRAP16, INCR16: burst_len = 5'd16;
            default:        burst_len = 5'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : ahb_rr_picker
// Description : Combinational round-robin search. Scans masters starting at
//               gnt_idx_i+1 (wrapping) and ending on gnt_idx_i itself, so a
//               lone requesting owner keeps the bus. With no requests the
//               result is DEFAULT_MASTER.
// Ports       : hbusreq_i  [NUM_MASTERS-1:0] request per master
//               gnt_idx_i  [IDX_W-1:0]       current grant index
//               next_idx_o [IDX_W-1:0]       winning master index
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_rr_picker
    import integration_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic [NUM_MASTERS-1:0]         hbusreq_i,
    input  logic [$clog2(NUM_MASTERS)-1:0] gnt_idx_i,
    output logic [$clog2(NUM_MASTERS)-1:0] next_idx_o
);

    localparam int C_IDX_W  = $clog2(NUM_MASTERS);
    // One extra bit so gnt_idx + offset (at most 2*NUM_MASTERS-1) never wraps.
    localparam int C_CAND_W = C_IDX_W + 1;

    logic [C_CAND_W-1:0] cand;
    logic                found;

    always_comb begin
        next_idx_o = C_IDX_W'(DEFAULT_MASTER);
        found      = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = {1'b0, gnt_idx_i} + C_CAND_W'(i);
            if (cand >= C_CAND_W'(NUM_MASTERS)) begin
                cand = cand - C_CAND_W'(NUM_MASTERS);
            end
            if (!found && hbusreq_i[cand[C_IDX_W-1:0]]) begin
                next_idx_o = cand[C_IDX_W-1:0];
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bus_arbiter
// Description : Multi-master AHB 2.0 bus arbiter. Issues a one-hot grant by
//               round-robin, drives hmaster/hmastlock one hready-high edge
//               behind the grant, and freezes arbitration during fixed-length
//               bursts and locked sequences.
// Ports       : hclk, hreset (async, active low)
//               hbusreq/hlock [NUM_MASTERS-1:0] per-master request / lock
//               htrans, hburst, hready, hresp   shared bus observation
//               hgrant [NUM_MASTERS-1:0]        one-hot grant
//               hmaster [3:0], hmastlock        current address-phase owner
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_bus_arbiter
    import integration_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [3:0]             hmaster,
    output logic                   hmastlock
);

    localparam int C_IDX_W = $clog2(NUM_MASTERS);

    logic [C_IDX_W-1:0]     gnt_idx_q,    gnt_idx_d;
    logic [C_HMASTER_W-1:0] hmaster_q,    hmaster_d;
    logic                   hmastlock_q,  hmastlock_d;
    logic [C_BEATS_W-1:0]   beats_left_q, beats_left_d;
    arb_state_e             state_q,      state_d;

    logic [C_IDX_W-1:0]     w_next_idx;
    logic                   w_owner_lock;
    htrans_e                w_trans;
    hburst_e                w_burst;
    hresp_e                 w_resp;

    assign w_trans      = htrans_e'(htrans);
    assign w_burst      = hburst_e'(hburst);
    assign w_resp       = hresp_e'(hresp);
    assign w_owner_lock = hlock[gnt_idx_q];

    ahb_rr_picker #(
        .NUM_MASTERS    (NUM_MASTERS),
        .DEFAULT_MASTER (DEFAULT_MASTER)
    ) u_rr_picker (
        .hbusreq_i  (hbusreq),
        .gnt_idx_i  (gnt_idx_q),
        .next_idx_o (w_next_idx)
    );

    always_comb begin
        beats_left_d = beats_left_q;
        state_d      = state_q;
        gnt_idx_d    = gnt_idx_q;
        hmaster_d    = hmaster_q;
        hmastlock_d  = hmastlock_q;

        if (hready) begin
            case (w_trans)
                NONSEQ: beats_left_d = C_BEATS_W'(burst_len(w_burst) - 5'd1);
                SEQ:    beats_left_d = (beats_left_q == '0) ? '0 : beats_left_q - 1'b1;
                BUSY:   beats_left_d = beats_left_q;
                IDLE:   beats_left_d = '0;
            endcase
        end

        // A non-OKAY response ends the burst early, even mid wait-state.
        if (w_resp != OKAY) begin
            beats_left_d = '0;
        end

        if (hready) begin
            hmaster_d   = C_HMASTER_W'(gnt_idx_q);
            hmastlock_d = w_owner_lock;

            if (w_owner_lock) begin
                state_d = ST_LOCKED;
            end else if (beats_left_d > C_BEATS_W'(1)) begin
                state_d = ST_BURST;
            end else begin
                state_d = ST_OPEN;
            end

            // Arbitrate on the edge that leaves the bus open, so a burst's
            // final-beat address phase already carries the next grant. The
            // edge that leaves LOCKED is skipped: the owner keeps the grant
            // for one more transfer after hlock drops.
            if (state_d == ST_OPEN && state_q != ST_LOCKED) begin
                gnt_idx_d = w_next_idx;
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) begin
            gnt_idx_q    <= C_IDX_W'(DEFAULT_MASTER);
            hmaster_q    <= C_HMASTER_W'(DEFAULT_MASTER);
            hmastlock_q  <= 1'b0;
            beats_left_q <= '0;
            state_q      <= ST_OPEN;
        end else begin
            gnt_idx_q    <= gnt_idx_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
            beats_left_q <= beats_left_d;
            state_q      <= state_d;
        end
    end

    // Grant is a pure decode of a register, so exactly one bit is high at
    // all times, including while reset is held.
    assign hgrant    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << gnt_idx_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_bus_arbiter
// Description : Directed self-checking bench for ahb_bus_arbiter with four
//               masters and DEFAULT_MASTER = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_bus_arbiter;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR8  = 3'd5;
    localparam logic [1:0] R_OKAY   = 2'd0;
    localparam logic [1:0] R_ERROR  = 2'd1;

    logic       hclk;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
    logic [3:0] hgrant;
    logic [3:0] hmaster;
    logic       hmastlock;

    int n_checks = 0;
    int n_pass   = 0;

    ahb_bus_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_idle();
        hbusreq = 4'b0000;
        hlock   = 4'b0000;
        htrans  = T_IDLE;
        hburst  = B_SINGLE;
        hready  = 1'b1;
        hresp   = R_OKAY;
    endtask

    // Bring the grant to master 1 with master 1 owning the address phase.
    task automatic own_master1();
        set_idle();
        cyc();
        cyc();
        hbusreq = 4'b0010;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        set_idle();
        hreset = 1'b1;
        #2;
        hreset = 1'b0;
        #1;
        n_checks++;
        if (hgrant !== 4'b0001) $display("FAIL reset_hgrant got=%b exp=%b", hgrant, 4'b0001);
        else n_pass++;
        n_checks++;
        if (hmaster !== 4'd0) $display("FAIL reset_hmaster got=%0d exp=0", hmaster);
        else n_pass++;
        n_checks++;
        if (hmastlock !== 1'b0) $display("FAIL reset_hmastlock got=%b exp=0", hmastlock);
        else n_pass++;
        n_checks++;
        if (dut.beats_left_q !== 4'd0) $display("FAIL reset_beats got=%0d exp=0", dut.beats_left_q);
        else n_pass++;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (hgrant !== 4'b0001) $display("FAIL idle_hgrant got=%b exp=%b", hgrant, 4'b0001);
        else n_pass++;
        n_checks++;
        if (hmaster !== 4'd0) $display("FAIL idle_hmaster got=%0d exp=0", hmaster);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [4];
        logic [3:0] exp_mst [4];
        exp_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
        exp_mst = '{4'd0, 4'd1, 4'd2, 4'd3};
        set_idle();
        hbusreq = 4'b1110;
        htrans  = T_NONSEQ;
        hburst  = B_SINGLE;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_checks++;
            if (hgrant !== exp_gnt[k]) $display("FAIL rr_hgrant[%0d] got=%b exp=%b", k, hgrant, exp_gnt[k]);
            else n_pass++;
            n_checks++;
            if (hmaster !== exp_mst[k]) $display("FAIL rr_hmaster[%0d] got=%0d exp=%0d", k, hmaster, exp_mst[k]);
            else n_pass++;
        end
        set_idle();
        cyc();
        n_checks++;
        if (hgrant !== 4'b0001) $display("FAIL rr_default got=%b exp=%b", hgrant, 4'b0001);
        else n_pass++;
    endtask

    task automatic test_incr4();
        own_master1();
        n_checks++;
        if (hmaster !== 4'd1) $display("FAIL incr4_setup_hmaster got=%0d exp=1", hmaster);
        else n_pass++;
        htrans  = T_NONSEQ;
        hburst  = B_INCR4;
        hbusreq = 4'b0110;
        cyc();
        n_checks++;
        if (hgrant !== 4'b0010) $display("FAIL incr4_beat2_hgrant got=%b exp=%b", hgrant, 4'b0010);
        else n_pass++;
        n_checks++;
        if (dut.beats_left_q !== 4'd3) $display("FAIL incr4_beat2_beats got=%0d exp=3", dut.beats_left_q);
        else n_pass++;
        htrans = T_SEQ;
        cyc();
        n_checks++;
        if (hgrant !== 4'b0010) $display("FAIL incr4_beat3_hgrant got=%b exp=%b", hgrant, 4'b0010);
        else n_pass++;
        cyc();
        n_checks++;
        if (hgrant !== 4'b0100) $display("FAIL incr4_beat4_hgrant got=%b exp=%b", hgrant, 4'b0100);
        else n_pass++;
        n_checks++;
        if (hmaster !== 4'd1) $display("FAIL incr4_beat4_hmaster got=%0d exp=1", hmaster);
        else n_pass++;
        hbusreq = 4'b0100;
        cyc();
        n_checks++;
        if (hmaster !== 4'd2) $display("FAIL incr4_handover_hmaster got=%0d exp=2", hmaster);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_wait_states();
        own_master1();
        htrans  = T_NONSEQ;
        hburst  = B_INCR4;
        hbusreq = 4'b0110;
        cyc();
        htrans = T_SEQ;
        hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if (dut.beats_left_q !== 4'd3) $display("FAIL wait_beats[%0d] got=%0d exp=3", k, dut.beats_left_q);
            else n_pass++;
            n_checks++;
            if (hgrant !== 4'b0010) $display("FAIL wait_hgrant[%0d] got=%b exp=%b", k, hgrant, 4'b0010);
            else n_pass++;
            n_checks++;
            if (hmaster !== 4'd1) $display("FAIL wait_hmaster[%0d] got=%0d exp=1", k, hmaster);
            else n_pass++;
        end
        hready = 1'b1;
        cyc();
        n_checks++;
        if (hgrant !== 4'b0010) $display("FAIL wait_beat3_hgrant got=%b exp=%b", hgrant, 4'b0010);
        else n_pass++;
        cyc();
        n_checks++;
        if (hgrant !== 4'b0100) $display("FAIL wait_beat4_hgrant got=%b exp=%b", hgrant, 4'b0100);
        else n_pass++;
        hbusreq = 4'b0100;
        cyc();
        n_checks++;
        if (hmaster !== 4'd2) $display("FAIL wait_handover_hmaster got=%0d exp=2", hmaster);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_locked();
        set_idle();
        cyc();
        hbusreq = 4'b1000;
        hlock   = 4'b1000;
        cyc();
        n_checks++;
        if (hgrant !== 4'b1000) $display("FAIL lock_grant got=%b exp=%b", hgrant, 4'b1000);
        else n_pass++;
        hbusreq = 4'b1001;
        cyc();
        n_checks++;
        if (hmastlock !== 1'b1) $display("FAIL lock_xfer1_hmastlock got=%b exp=1", hmastlock);
        else n_pass++;
        n_checks++;
        if (hmaster !== 4'd3) $display("FAIL lock_xfer1_hmaster got=%0d exp=3", hmaster);
        else n_pass++;
        htrans = T_NONSEQ;
        hburst = B_SINGLE;
        cyc();
        n_checks++;
        if (hmastlock !== 1'b1) $display("FAIL lock_xfer2_hmastlock got=%b exp=1", hmastlock);
        else n_pass++;
        n_checks++;
        if (hgrant !== 4'b1000) $display("FAIL lock_xfer2_hgrant got=%b exp=%b", hgrant, 4'b1000);
        else n_pass++;
        hlock   = 4'b0000;
        hbusreq = 4'b0001;
        cyc();
        n_checks++;
        if (hgrant !== 4'b1000) $display("FAIL lock_tail_hgrant got=%b exp=%b", hgrant, 4'b1000);
        else n_pass++;
        n_checks++;
        if (hmastlock !== 1'b0) $display("FAIL lock_tail_hmastlock got=%b exp=0", hmastlock);
        else n_pass++;
        htrans = T_IDLE;
        cyc();
        n_checks++;
        if (hgrant !== 4'b0001) $display("FAIL lock_release_hgrant got=%b exp=%b", hgrant, 4'b0001);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_error();
        own_master1();
        htrans  = T_NONSEQ;
        hburst  = B_INCR8;
        hbusreq = 4'b0110;
        cyc();
        n_checks++;
        if (dut.beats_left_q !== 4'd7) $display("FAIL err_load_beats got=%0d exp=7", dut.beats_left_q);
        else n_pass++;
        htrans = T_SEQ;
        cyc();
        n_checks++;
        if (dut.beats_left_q !== 4'd6) $display("FAIL err_dec_beats got=%0d exp=6", dut.beats_left_q);
        else n_pass++;
        hready = 1'b0;
        hresp  = R_ERROR;
        cyc();
        n_checks++;
        if (dut.beats_left_q !== 4'd0) $display("FAIL err_clear_beats got=%0d exp=0", dut.beats_left_q);
        else n_pass++;
        n_checks++;
        if (hgrant !== 4'b0010) $display("FAIL err_hold_hgrant got=%b exp=%b", hgrant, 4'b0010);
        else n_pass++;
        hready = 1'b1;
        htrans = T_IDLE;
        cyc();
        n_checks++;
        if (hgrant !== 4'b0100) $display("FAIL err_reopen_hgrant got=%b exp=%b", hgrant, 4'b0100);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_reset_in_lock();
        set_idle();
        cyc();
        hbusreq = 4'b1000;
        hlock   = 4'b1000;
        cyc();
        cyc();
        n_checks++;
        if (hmastlock !== 1'b1) $display("FAIL rstlock_pre_hmastlock got=%b exp=1", hmastlock);
        else n_pass++;
        #2;
        hreset = 1'b0;
        #1;
        n_checks++;
        if (hmastlock !== 1'b0) $display("FAIL rstlock_hmastlock got=%b exp=0", hmastlock);
        else n_pass++;
        n_checks++;
        if (hgrant !== 4'b0001) $display("FAIL rstlock_hgrant got=%b exp=%b", hgrant, 4'b0001);
        else n_pass++;
        n_checks++;
        if (hmaster !== 4'd0) $display("FAIL rstlock_hmaster got=%0d exp=0", hmaster);
        else n_pass++;
        set_idle();
        @(negedge hclk);
        hreset = 1'b1;
        hbusreq = 4'b0010;
        cyc();
        n_checks++;
        if (hgrant !== 4'b0010) $display("FAIL rstlock_open_hgrant got=%b exp=%b", hgrant, 4'b0010);
        else n_pass++;
        set_idle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_incr4();
        test_wait_states();
        test_locked();
        test_error();
        test_reset_in_lock();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
